// File: rtl/uart_cmd_regfile.sv
// uart_cmd_regfile: decodes 32-bit command words from the UART RX register
// stage into writes/reads of a bank of 16-bit control registers. Read and
// error responses leave over a valid/ready handshake toward the UART TX stage.
// Command word: [31:24] opcode, [23:16] addr, [15:0] data.
module uart_cmd_regfile #(
  parameter int          REG_NUM  = 16,
  parameter logic [15:0] ID_VALUE = 16'h5A01
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             uart_rx_reg,
  input  logic                    uart_rx_ack,
  output logic [31:0]             tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [REG_NUM*16-1:0]   regs_out,
  output logic                    wr_strobe,
  output logic [7:0]              wr_addr,
  output logic                    busy,
  output logic [7:0]              err_cnt,
  output logic                    overrun
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_READ = 8'h82;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] cmd_r;
  logic [31:0] tx_data_r;
  logic        tx_valid_r;
  logic        wr_strobe_r;
  logic [7:0]  wr_addr_r;
  logic        busy_r;
  logic [7:0]  err_cnt_r;
  logic        overrun_r;

  // Register 0 is the read-only ID constant, so only 1..REG_NUM-1 are stored.
  logic [15:0] regs_r [1:REG_NUM-1];

  logic [7:0]  opcode_s;
  logic [7:0]  addr_s;
  logic [15:0] data_s;
  logic        addr_in_range_s;
  logic        wr_en_s;
  logic        rd_ok_s;
  logic [15:0] rd_data_s;

  assign opcode_s = cmd_r[31:24];
  assign addr_s   = cmd_r[23:16];
  assign data_s   = cmd_r[15:0];
  // Widened to 9 bits so REG_NUM=256 still compares as plain unsigned.
  assign addr_in_range_s = ({1'b0, addr_s} < 9'(REG_NUM));

  // Read mux: address 0 (and anything unmatched) yields the ID constant.
  always_comb begin
    rd_data_s = ID_VALUE;
    for (int i = 1; i < REG_NUM; i++) begin
      rd_data_s = (addr_s == 8'(i)) ? regs_r[i] : rd_data_s;
    end
  end

  // Classify the latched command while in DECODE.
  always_comb begin
    wr_en_s = 1'b0;
    rd_ok_s = 1'b0;
    if (state_r == ST_DECODE) begin
      if ((opcode_s == OP_WRITE) && addr_in_range_s && (addr_s != 8'd0)) begin
        wr_en_s = 1'b1;
      end else begin
        wr_en_s = 1'b0;
      end
      if ((opcode_s == OP_READ) && addr_in_range_s) begin
        rd_ok_s = 1'b1;
      end else begin
        rd_ok_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
      rd_ok_s = 1'b0;
    end
  end

  // Register bank: updated at the end of DECODE for a legal write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (wr_en_s && (addr_s == 8'(i))) begin
          regs_r[i] <= data_s;
        end
      end
    end
  end

  // Command FSM with all handshake/status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_r       <= 32'h0000_0000;
      tx_data_r   <= 32'h0000_0000;
      tx_valid_r  <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= 8'h00;
      busy_r      <= 1'b0;
      err_cnt_r   <= 8'h00;
      overrun_r   <= 1'b0;
    end else begin
      wr_strobe_r <= 1'b0;
      // A word arriving while busy is dropped and flagged for good.
      if (uart_rx_ack && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (uart_rx_ack) begin
            cmd_r   <= uart_rx_reg;
            state_r <= ST_DECODE;
            busy_r  <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (wr_en_s) begin
            wr_strobe_r <= 1'b1;
            wr_addr_r   <= addr_s;
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
          end else if (rd_ok_s) begin
            tx_data_r  <= {RSP_READ, addr_s, rd_data_s};
            tx_valid_r <= 1'b1;
            state_r    <= ST_RESP;
          end else begin
            tx_data_r  <= {RSP_ERR, addr_s, 8'h00, opcode_s};
            tx_valid_r <= 1'b1;
            state_r    <= ST_RESP;
            if (err_cnt_r != 8'hFF) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end
          end
        end
        ST_RESP: begin
          // tx_valid is always high here, so tx_ready alone completes it.
          if (tx_ready) begin
            tx_valid_r <= 1'b0;
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the bank; slice 0 is hard-wired to the ID constant.
  always_comb begin
    regs_out        = '0;
    regs_out[15:0]  = ID_VALUE;
    for (int i = 1; i < REG_NUM; i++) begin
      regs_out[i*16 +: 16] = regs_r[i];
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign busy      = busy_r;
  assign err_cnt   = err_cnt_r;
  assign overrun   = overrun_r;

endmodule
